// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces the push buttons and slide
// switches. Every bit has its own stability counter, and all bits share one
// prescaler. The block delivers clean levels plus single-cycle edge pulses.
// Buttons and switches are packed into one vector internally (buttons in the
// low bits) so that both kinds of bit go through the same per-bit logic.

module input_conditioner #(
    parameter int N_BTN        = 2,
    parameter int N_SW         = 10,
    parameter int TICK_CYCLES  = 50000,
    parameter int STABLE_TICKS = 10
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [N_BTN-1:0]  btn_raw_,
    input  logic [N_SW-1:0]   sw_raw,
    output logic [N_BTN-1:0]  btn_,
    output logic [N_BTN-1:0]  btn_press,
    output logic [N_BTN-1:0]  btn_release,
    output logic [N_SW-1:0]   sw,
    output logic [N_SW-1:0]   sw_change,
    output logic              valid
);

    localparam int N  = N_BTN + N_SW;
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);

    // Idle level of every bit: buttons are active-low (idle 1), switches idle 0.
    localparam logic [N-1:0] IDLE_VAL = {{N_SW{1'b0}}, {N_BTN{1'b1}}};

    localparam logic [PW-1:0] TICK_LAST   = PW'(TICK_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_TICKS - 1);

    logic [N-1:0]     raw;
    logic [N-1:0]     meta_q;
    logic [N-1:0]     sync_q;
    logic [PW-1:0]    presc_q;
    logic             tick;
    logic [CW-1:0]    init_q;
    logic             valid_q;
    logic [N-1:0]     deb_q;
    logic [N-1:0]     deb_d;
    logic [CW-1:0]    cnt_q [N];
    logic [CW-1:0]    cnt_d [N];
    logic [N-1:0]     edge_d;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] release_q;
    logic [N_SW-1:0]  change_q;

    assign raw  = {sw_raw, btn_raw_};
    assign tick = (presc_q == TICK_LAST);

    // Two-flop synchroniser on every raw pin. Each flop resets to the bit's idle level.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            meta_q <= IDLE_VAL;
            sync_q <= IDLE_VAL;
        end else begin
            // NOTE: non-blocking assignments make sync_q take the old meta_q,
            // so the chain really is two stages deep.
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    // Shared prescaler. It wraps at TICK_CYCLES-1, and tick marks the wrap cycle.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // Init phase: count STABLE_TICKS ticks, then raise valid. Once valid is high,
    // the counter freezes.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            init_q  <= '0;
            valid_q <= 1'b0;
        end else if (!valid_q && tick) begin
            init_q <= init_q + CW'(1);
            if (init_q == STABLE_LAST) begin
                valid_q <= 1'b1;
            end
        end
    end

    // Per-bit qualification. During init the debounced state simply tracks the
    // synchronised input.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the loop can leave a value unassigned and infer a latch.
        deb_d  = deb_q;
        edge_d = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        if (!valid_q) begin
            deb_d = sync_q;
            for (int i = 0; i < N; i++) begin
                cnt_d[i] = '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sync_q[i] == deb_q[i]) begin
                    // A bounce back to the accepted level restarts qualification.
                    cnt_d[i] = '0;
                end else if (tick) begin
                    if (cnt_q[i] == STABLE_LAST) begin
                        deb_d[i]  = sync_q[i];
                        cnt_d[i]  = '0;
                        edge_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
            end
        end
    end

    // Debounced state, counters and edge pulses. The pulses are registered so
    // that they line up with the first cycle of the new level.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            deb_q <= IDLE_VAL;
            // NOTE: cnt_q is a bank of flops rather than a RAM, so it takes the
            // asynchronous reset like any other state. This discards any pending
            // qualification.
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
            press_q   <= '0;
            release_q <= '0;
            change_q  <= '0;
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            press_q   <= edge_d[N_BTN-1:0] & ~deb_d[N_BTN-1:0];
            release_q <= edge_d[N_BTN-1:0] &  deb_d[N_BTN-1:0];
            change_q  <= edge_d[N-1:N_BTN];
        end
    end

    assign btn_        = deb_q[N_BTN-1:0];
    assign sw          = deb_q[N-1:N_BTN];
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign sw_change   = change_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with TICK_CYCLES=4 and STABLE_TICKS=3.
// A table of held input segments checks levels and pulse counts. Hand-written
// sequences check exact latencies, simultaneous pulses, mid-run reset and
// the tick/bounce coincidence.

module tb_input_conditioner;

    localparam int N_BTN = 2;
    localparam int N_SW  = 10;

    logic             clk;
    logic             rst_;
    logic [N_BTN-1:0] btn_raw_;
    logic [N_SW-1:0]  sw_raw;
    logic [N_BTN-1:0] btn_;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_SW-1:0]  sw;
    logic [N_SW-1:0]  sw_change;
    logic             valid;

    input_conditioner #(
        .N_BTN(N_BTN), .N_SW(N_SW), .TICK_CYCLES(4), .STABLE_TICKS(3)
    ) dut (
        .clk(clk), .rst_(rst_), .btn_raw_(btn_raw_), .sw_raw(sw_raw),
        .btn_(btn_), .btn_press(btn_press), .btn_release(btn_release),
        .sw(sw), .sw_change(sw_change), .valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since the last reset release. The prescaler phase equals cyc mod 4.
    int cyc;
    always @(posedge clk or negedge rst_) begin
        if (!rst_) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Pulse monitor. It samples on the falling edge and keeps running totals.
    int press_cyc, release_cyc, change_cyc, excl_viol;
    initial begin
        press_cyc = 0; release_cyc = 0; change_cyc = 0; excl_viol = 0;
    end
    always @(negedge clk) begin
        if (rst_) begin
            if (btn_press != '0)   press_cyc   <= press_cyc + 1;
            if (btn_release != '0) release_cyc <= release_cyc + 1;
            if (sw_change != '0)   change_cyc  <= change_cyc + 1;
            if ((btn_press & btn_release) != '0) excl_viol <= excl_viol + 1;
        end
    end

    int total, bad;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 200) begin
            step();
            guard++;
        end
    endtask

    // Step until valid rises. Returns the edge index, or -1 if valid never rises.
    task automatic wait_valid(output int rise_at);
        rise_at = -1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (valid) begin
                rise_at = cyc;
                break;
            end
        end
    endtask

    typedef struct {
        logic [N_BTN-1:0] btn_raw;
        logic [N_SW-1:0]  sw_raw;
        int               hold;
        logic [N_BTN-1:0] exp_btn;
        logic [N_SW-1:0]  exp_sw;
        int               exp_press;
        int               exp_release;
        int               exp_change;
    } vec_t;

    vec_t vecs[9];

    int rise_at, lat, p0, r0, c0;

    initial begin
        total = 0;
        bad   = 0;

        // Segments start from btn_=01 (button 1 held down) and sw=2A5.
        // Glitches of 6 or 8 cycles are shorter than the 9-cycle rejection limit.
        // Holds of 16 cycles cover the worst-case 14-cycle acceptance latency.
        vecs[0] = '{2'b00, 10'h2A5,  6, 2'b01, 10'h2A5, 0, 0, 0}; // bounce low 6
        vecs[1] = '{2'b01, 10'h2A5,  2, 2'b01, 10'h2A5, 0, 0, 0}; // back high 2
        vecs[2] = '{2'b00, 10'h2A5,  6, 2'b01, 10'h2A5, 0, 0, 0}; // bounce low 6
        vecs[3] = '{2'b01, 10'h2A5, 16, 2'b01, 10'h2A5, 0, 0, 0}; // settle high
        vecs[4] = '{2'b01, 10'h0F0, 16, 2'b01, 10'h0F0, 0, 0, 1}; // many sw bits at once
        vecs[5] = '{2'b00, 10'h0F0, 16, 2'b00, 10'h0F0, 1, 0, 0}; // press btn0
        vecs[6] = '{2'b01, 10'h0F0, 16, 2'b01, 10'h0F0, 0, 1, 0}; // release btn0
        vecs[7] = '{2'b01, 10'h0D0,  8, 2'b01, 10'h0F0, 0, 0, 0}; // 8-cycle sw5 glitch
        vecs[8] = '{2'b01, 10'h0F0, 16, 2'b01, 10'h0F0, 0, 0, 0}; // settle

        // ---- Reset and init ----
        rst_     = 1'b0;
        btn_raw_ = 2'b11;
        sw_raw   = 10'h2A5;
        step(); step(); step();
        check("rst_btn", 32'(btn_), 32'h3);
        check("rst_sw", 32'(sw), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_press", 32'(btn_press), 32'h0);
        check("rst_release", 32'(btn_release), 32'h0);
        check("rst_change", 32'(sw_change), 32'h0);
        c0 = change_cyc;
        rst_ = 1'b1;
        wait_valid(rise_at);
        check("init_valid_rise", 32'(rise_at), 32'd12);
        check("init_sw", 32'(sw), 32'h2A5);
        check("init_no_change", 32'(change_cyc - c0), 32'd0);

        // ---- Clean press of button 1 ----
        p0 = press_cyc; r0 = release_cyc;
        btn_raw_ = 2'b01;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (btn_[1] == 1'b0) begin
                lat = k;
                break;
            end
        end
        check("press_latency_window", 32'(lat >= 11 && lat <= 14), 32'd1);
        check("press_pulse_value", 32'(btn_press), 32'h2);
        step();
        check("press_pulse_cleared", 32'(btn_press), 32'h0);
        step();
        check("press_pulse_count", 32'(press_cyc - p0), 32'd1);
        check("press_no_release", 32'(release_cyc - r0), 32'd0);

        // ---- Table: bounce rejection and single-bit/multi-bit changes ----
        for (int v = 0; v < 9; v++) begin
            p0 = press_cyc; r0 = release_cyc; c0 = change_cyc;
            btn_raw_ = vecs[v].btn_raw;
            sw_raw   = vecs[v].sw_raw;
            for (int k = 0; k < vecs[v].hold; k++) step();
            check($sformatf("vec%0d_btn", v), 32'(btn_), 32'(vecs[v].exp_btn));
            check($sformatf("vec%0d_sw", v), 32'(sw), 32'(vecs[v].exp_sw));
            check($sformatf("vec%0d_press", v), 32'(press_cyc - p0), 32'(vecs[v].exp_press));
            check($sformatf("vec%0d_release", v), 32'(release_cyc - r0), 32'(vecs[v].exp_release));
            check($sformatf("vec%0d_change", v), 32'(change_cyc - c0), 32'(vecs[v].exp_change));
        end

        // ---- Release of button 1 together with sw[0] and sw[9] ----
        btn_raw_ = 2'b11;
        sw_raw   = 10'h2F1;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (btn_release != '0) begin
                lat = k;
                break;
            end
        end
        check("rel_seen", 32'(lat > 0), 32'd1);
        check("rel_value", 32'(btn_release), 32'h2);
        check("rel_sw_change", 32'(sw_change), 32'h201);
        check("rel_sw_level", 32'(sw), 32'h2F1);
        check("rel_btn_level", 32'(btn_), 32'h3);

        // ---- Reset in the middle of a qualification ----
        sw_raw = 10'h2F9;
        for (int k = 0; k < 8; k++) step();
        rst_ = 1'b0;
        #1;
        check("mid_rst_btn", 32'(btn_), 32'h3);
        check("mid_rst_sw", 32'(sw), 32'h0);
        check("mid_rst_valid", 32'(valid), 32'h0);
        check("mid_rst_press", 32'(btn_press), 32'h0);
        check("mid_rst_release", 32'(btn_release), 32'h0);
        check("mid_rst_change", 32'(sw_change), 32'h0);
        @(posedge clk);
        #1;
        c0 = change_cyc;
        rst_ = 1'b1;
        wait_valid(rise_at);
        check("mid_rst_valid_rise", 32'(rise_at), 32'd12);
        check("mid_rst_sw_adopted", 32'(sw), 32'h2F9);
        check("mid_rst_no_change", 32'(change_cyc - c0), 32'd0);

        // ---- Tick/bounce coincidence on sw[5] ----
        // The raw change is driven after edge 12, so s changes at edge 14 and
        // the ticks at edges 16 and 20 count. The raw restore is driven after
        // edge 21, so s is back at edge 23, the third tick cycle.
        c0 = change_cyc;
        sw_raw = 10'h2D9;
        wait_until(21);
        sw_raw = 10'h2F9;
        wait_until(24);
        check("coin_sw_kept", 32'(sw), 32'h2F9);
        check("coin_no_change", 32'(change_cyc - c0), 32'd0);
        // With the counter cleared, a new change needs three fresh ticks
        // (edges 28, 32 and 36), so nothing may happen at edge 28.
        sw_raw = 10'h2D9;
        wait_until(35);
        check("coin_restart_pending", 32'(sw), 32'h2F9);
        wait_until(36);
        check("coin_restart_accept", 32'(sw), 32'h2D9);
        check("coin_restart_pulse", 32'(sw_change), 32'h020);

        step();
        check("press_release_exclusive", 32'(excl_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Synchronises and debounces the DE10-Lite push buttons and slide switches before they enter the `marvin` core. It sits directly upstream of the core's `btn_`/`sw` inputs. It delivers clean levels plus single-cycle edge pulses so that core logic never sees metastable or bouncing inputs. Reset-button conditioning is out of scope; `rst_` comes from outside this block.

## Interface
- `N_BTN`, default 2: number of active-low push buttons.
- `N_SW`, default 10: number of slide switches.
- `TICK_CYCLES`, default 50000: clock cycles per debounce tick (1 ms at 50 MHz); minimum 2.
- `STABLE_TICKS`, default 10: consecutive ticks a new value must persist before it is accepted; minimum 1.
- `clk`  in  1: system clock. Single clock domain.
- `rst_`  in  1: reset, asynchronous, active-low.
- `btn_raw_`  in  N_BTN: raw button pins, active-low, asynchronous.
- `sw_raw`  in  N_SW: raw switch pins, asynchronous.
- `btn_`  out  N_BTN: debounced button levels, active-low.
- `btn_press`  out  N_BTN: one-cycle pulse on debounced 1→0 of `btn_`.
- `btn_release`  out  N_BTN: one-cycle pulse on debounced 0→1 of `btn_`.
- `sw`  out  N_SW: debounced switch levels.
- `sw_change`  out  N_SW: one-cycle pulse on any debounced change of `sw`.
- `valid`  out  1: high once the initial sampling period has completed.

## Operation
- **Synchroniser:** each raw bit passes through a 2-flop chain, giving synced value `s`. Button flops reset to 1; switch flops reset to 0.
- **Prescaler:** counter `0..TICK_CYCLES-1`, wraps to 0. `tick` is high for one cycle when count == TICK_CYCLES-1. One prescaler is shared by all bits.
- **Init phase** (`valid`=0):
  - Every debounced register copies `s` every cycle.
  - All pulses are held at 0. All per-bit counters are held at 0.
  - An init counter counts ticks. On the STABLE_TICKS-th tick after reset release, `valid` goes high and stays high until reset.
- **Run phase, per bit** (debounced state `d`, counter `c`, width clog2(STABLE_TICKS+1)):
  - `s == d`: `c` ← 0 in that cycle. Any bounce back to the old value restarts qualification.
  - `s != d`, no tick: `c` holds.
  - `s != d`, tick, `c == STABLE_TICKS-1`: `d` ← `s`, `c` ← 0, edge pulse asserted.
  - `s != d`, tick, otherwise: `c` ← `c`+1.
- **Pulses:**
  - Pulses are registered and asserted in the same cycle the new `d` is first visible. They are high for exactly one cycle.
  - `btn_press`/`btn_release` are mutually exclusive per bit.
  - Several bits may pulse in the same cycle. Bits are fully independent.
- **Reset values:** `btn_`=all 1, `btn_press`=0, `btn_release`=0, `sw`=0, `sw_change`=0, `valid`=0. Prescaler, init counter and all `c` are 0.
- **Reset mid-operation:** asserting `rst_` immediately forces all the reset values above. Pending qualifications are discarded. After release, the block re-enters the init phase, and no pulse is generated for the state adopted during init.

## Timing
- Sync latency: 2 cycles from raw pin to `s`.
- Acceptance latency: a change of `s` held continuously is accepted on the STABLE_TICKS-th tick edge after it appears.
  - In cycles after `s` changes, the latency lies in [(STABLE_TICKS-1)·TICK_CYCLES+1, STABLE_TICKS·TICK_CYCLES].
  - Add 2 cycles for raw-pin to `s`.
- Minimum rejected glitch: any excursion shorter than (STABLE_TICKS-1)·TICK_CYCLES+1 cycles never changes `d`.
- If `s` returns to `d` in the same cycle as a tick, the counter clears and no acceptance occurs.
- `valid` rises on the clock edge of the STABLE_TICKS-th tick, i.e. STABLE_TICKS·TICK_CYCLES cycles after reset release.
- Prescaler and init counter wrap or saturate silently. There is no overflow at any parameter value within the stated minimums.

## Test plan
Parameters for the bench: TICK_CYCLES=4, STABLE_TICKS=3, N_BTN=2, N_SW=10.

- **Reset/init:**
  - Hold `sw_raw`=10'h2A5 and `btn_raw_`=2'b11, then release `rst_`.
  - Required: `valid` rises exactly 12 cycles after release; `sw`=10'h2A5; `sw_change` never pulses.
- **Clean press:**
  - After `valid`, drive `btn_raw_[1]`=0 and hold it.
  - Required: `btn_[1]` falls 11–14 cycles later (2-cycle sync plus 9–12 cycles); `btn_press`=2'b10 for exactly one cycle; `btn_release`=0 throughout.
- **Bounce rejection:**
  - Toggle `btn_raw_[0]` low for 6 cycles, high for 2, low for 6, then high.
  - Required: `btn_[0]` stays 1; no pulses.
- **Release plus simultaneous switches:**
  - With `btn_[1]`=0, in the same cycle set `btn_raw_[1]`=1 and `sw_raw[0]`, `sw_raw[9]` to 1.
  - Required: `btn_release[1]` and `sw_change`=10'h201 pulse in the same cycle; `sw` bits 0 and 9 update in that cycle.
- **Reset mid-qualification:**
  - Hold `sw_raw[3]`=1 for 8 cycles, assert `rst_` for 1 cycle, then keep `sw_raw[3]`=1.
  - Required: all outputs go to reset values asynchronously; after release, `sw[3]`=1 is adopted during init with `sw_change[3]` never pulsing.
- **Tick/bounce coincidence:**
  - After 2 accepted ticks of a `sw_raw[5]` change, return the raw value so that `s` equals `d` exactly on the third tick cycle.
  - Required: `sw[5]` is unchanged; `c` is cleared.
